// File: rtl/uart_echo_fifo.sv
// Buffered echo bridge between a UART receiver and transmitter: received words are queued
// in a FIFO, optionally transformed at dequeue, and issued one at a time with a start/busy handshake.
module uart_echo_fifo #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned MODE         = 0,
    parameter int unsigned BUSY_TIMEOUT = 1024,
    parameter int unsigned LED_STRETCH  = 1_200_000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     rx_ready,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [7:0]               drop_count,
    output logic                     tx_timeout,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     led
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam int unsigned TW         = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int unsigned LW         = (LED_STRETCH > 0) ? $clog2(LED_STRETCH + 1) : 1;
    localparam int unsigned TMO_LAST_I = (BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0;

    localparam logic [AW:0]           FULL_LVL = DEPTH[AW:0];
    localparam logic [TW-1:0]         TMO_LAST = TMO_LAST_I[TW-1:0];
    localparam logic [LW-1:0]         LED_LOAD = LED_STRETCH[LW-1:0];
    localparam logic [DATA_WIDTH-1:0] LOWER_A  = DATA_WIDTH'(8'h61);
    localparam logic [DATA_WIDTH-1:0] LOWER_Z  = DATA_WIDTH'(8'h7A);
    localparam logic [DATA_WIDTH-1:0] CASE_OFS = DATA_WIDTH'(8'h20);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic                    tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    overflow_q, overflow_d;
    logic [7:0]              drop_q, drop_d;
    logic                    timeout_q, timeout_d;
    logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic [LW-1:0]           led_cnt_q, led_cnt_d;

    logic [AW:0]             level;
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    push;
    logic                    drop;
    logic [DATA_WIDTH-1:0]   head;

    function automatic logic [DATA_WIDTH-1:0] xform(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        r = w;
        if (MODE == 2) begin
            r = ~w;
        end else if (MODE == 1 && DATA_WIDTH == 8) begin
            if (w >= LOWER_A && w <= LOWER_Z) r = w - CASE_OFS;
        end
        return r;
    endfunction

    // Extra pointer bit makes the difference DEPTH when full and 0 when empty.
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign pop   = (state_q == IDLE) && !empty && !tx_busy;
    assign push  = rx_ready && (!full || pop);
    assign drop  = rx_ready && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= rx_data;
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        timeout_d  = timeout_q;
        tmo_cnt_d  = tmo_cnt_q;
        led_cnt_d  = (led_cnt_q != '0) ? led_cnt_q - 1'b1 : led_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        if (overflow_clr) begin
            overflow_d = 1'b0;
            drop_d     = '0;
            timeout_d  = 1'b0;
        end
        // A drop on the clearing edge still registers as the first drop.
        if (drop) begin
            overflow_d = 1'b1;
            if (overflow_clr)        drop_d = 8'd1;
            else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    tx_data_d  = xform(head);
                    tx_start_d = 1'b1;
                    led_cnt_d  = LED_LOAD;
                    tmo_cnt_d  = '0;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = WAIT_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tx_start_d = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            timeout_q  <= 1'b0;
            tmo_cnt_q  <= '0;
            led_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            timeout_q  <= timeout_d;
            tmo_cnt_q  <= tmo_cnt_d;
            led_cnt_q  <= led_cnt_d;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign tx_timeout = timeout_q;
    assign fifo_level = level;
    assign led        = (led_cnt_q != '0);

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: three instances (passthrough, to-upper, invert) share one stimulus
// stream; a scoreboard queue holds the expected word per instance in arrival order.
module tb_uart_echo_fifo;

    localparam int DW       = 8;
    localparam int DEPTH    = 16;
    localparam int TMO      = 8;
    localparam int LEDS     = 40;
    localparam int BUSY_LEN = 100;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       overflow_clr;
    logic       tx_auto;
    logic       auto_busy;
    logic       man_busy;
    logic       tx_busy;

    logic       tx_start_w [3];
    logic [7:0] tx_data_w  [3];
    logic       overflow_w [3];
    logic [7:0] drop_w     [3];
    logic       tmo_w      [3];
    logic [4:0] level_w    [3];
    logic       led_w      [3];

    always #5 clk = ~clk;

    assign tx_busy = tx_auto ? auto_busy : man_busy;

    uart_echo_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MODE(0), .BUSY_TIMEOUT(TMO), .LED_STRETCH(LEDS)) u_m0 (
        .clk(clk), .resetn(resetn), .rx_ready(rx_ready), .rx_data(rx_data), .tx_busy(tx_busy),
        .tx_start(tx_start_w[0]), .tx_data(tx_data_w[0]), .overflow(overflow_w[0]),
        .overflow_clr(overflow_clr), .drop_count(drop_w[0]), .tx_timeout(tmo_w[0]),
        .fifo_level(level_w[0]), .led(led_w[0])
    );
    uart_echo_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MODE(1), .BUSY_TIMEOUT(TMO), .LED_STRETCH(LEDS)) u_m1 (
        .clk(clk), .resetn(resetn), .rx_ready(rx_ready), .rx_data(rx_data), .tx_busy(tx_busy),
        .tx_start(tx_start_w[1]), .tx_data(tx_data_w[1]), .overflow(overflow_w[1]),
        .overflow_clr(overflow_clr), .drop_count(drop_w[1]), .tx_timeout(tmo_w[1]),
        .fifo_level(level_w[1]), .led(led_w[1])
    );
    uart_echo_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MODE(2), .BUSY_TIMEOUT(TMO), .LED_STRETCH(LEDS)) u_m2 (
        .clk(clk), .resetn(resetn), .rx_ready(rx_ready), .rx_data(rx_data), .tx_busy(tx_busy),
        .tx_start(tx_start_w[2]), .tx_data(tx_data_w[2]), .overflow(overflow_w[2]),
        .overflow_clr(overflow_clr), .drop_count(drop_w[2]), .tx_timeout(tmo_w[2]),
        .fifo_level(level_w[2]), .led(led_w[2])
    );

    typedef struct packed {
        logic [7:0] m0;
        logic [7:0] m1;
        logic [7:0] m2;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        exp_t       exp;
    } vec_t;

    exp_t sb [$];
    vec_t vecs [9];

    int   n_pass = 0;
    int   n_total = 0;
    logic prev_start;
    int   dly;
    int   busy_left;

    function automatic exp_t model(input logic [7:0] v);
        exp_t e;
        e.m0 = v;
        e.m1 = (v >= 8'h61 && v <= 8'h7A) ? (v & 8'hDF) : v;
        e.m2 = v ^ 8'hFF;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One clock: sample after the edge, score any new start, then advance the tx model.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (tx_start_w[0] && !prev_start) begin
            check("sb_nonempty_at_start", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("tx_data_mode0", tx_data_w[0], e.m0);
                check("tx_data_mode1", tx_data_w[1], e.m1);
                check("tx_data_mode2", tx_data_w[2], e.m2);
            end
        end
        prev_start = tx_start_w[0];
        if (tx_auto) begin
            if (auto_busy) begin
                busy_left--;
                if (busy_left == 0) auto_busy = 1'b0;
            end else if (tx_start_w[0]) begin
                if (dly >= 1) begin
                    auto_busy = 1'b1;
                    busy_left = BUSY_LEN;
                    dly = 0;
                end else begin
                    dly++;
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] v, input bit accept, input exp_t e);
        rx_ready = 1'b1;
        rx_data  = v;
        if (accept) sb.push_back(e);
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic set_auto();
        dly       = 0;
        busy_left = 0;
        auto_busy = 1'b0;
        tx_auto   = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (sb.size() == 0 && !tx_busy && !tx_start_w[0]) done = 1'b1;
            else tick();
        end
        check(name, 32'(done), 1);
        tick();
        tick();
    endtask

    initial begin
        int n;

        vecs[0] = '{din: 8'h41, exp: '{m0: 8'h41, m1: 8'h41, m2: 8'hBE}};
        vecs[1] = '{din: 8'h61, exp: '{m0: 8'h61, m1: 8'h41, m2: 8'h9E}};
        vecs[2] = '{din: 8'h7A, exp: '{m0: 8'h7A, m1: 8'h5A, m2: 8'h85}};
        vecs[3] = '{din: 8'h5B, exp: '{m0: 8'h5B, m1: 8'h5B, m2: 8'hA4}};
        vecs[4] = '{din: 8'h31, exp: '{m0: 8'h31, m1: 8'h31, m2: 8'hCE}};
        vecs[5] = '{din: 8'h0F, exp: '{m0: 8'h0F, m1: 8'h0F, m2: 8'hF0}};
        vecs[6] = '{din: 8'h60, exp: '{m0: 8'h60, m1: 8'h60, m2: 8'h9F}};
        vecs[7] = '{din: 8'h7B, exp: '{m0: 8'h7B, m1: 8'h7B, m2: 8'h84}};
        vecs[8] = '{din: 8'hE1, exp: '{m0: 8'hE1, m1: 8'hE1, m2: 8'h1E}};

        resetn       = 1'b0;
        rx_ready     = 1'b0;
        rx_data      = 8'h00;
        overflow_clr = 1'b0;
        man_busy     = 1'b0;
        prev_start   = 1'b0;
        set_auto();

        #22;
        check("rst_tx_start", tx_start_w[0], 0);
        check("rst_tx_data", tx_data_w[0], 0);
        check("rst_overflow", overflow_w[0], 0);
        check("rst_drop_count", drop_w[0], 0);
        check("rst_tx_timeout", tmo_w[0], 0);
        check("rst_fifo_level", level_w[0], 0);
        check("rst_led", led_w[0], 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Single word latency and handshake
        rx_ready = 1'b1;
        rx_data  = 8'h41;
        sb.push_back(model(8'h41));
        tick();
        rx_ready = 1'b0;
        check("lat_e0_tx_start", tx_start_w[0], 0);
        check("lat_e0_level", level_w[0], 1);
        tick();
        check("lat_e1_tx_start", tx_start_w[0], 1);
        check("lat_e1_level", level_w[0], 0);
        check("lat_e1_led", led_w[0], 1);
        tick();
        check("hold_start_until_busy", tx_start_w[0], 1);
        tick();
        check("start_drops_after_busy", tx_start_w[0], 0);
        repeat (37) tick();
        check("led_last_lit_cycle", led_w[0], 1);
        tick();
        check("led_expired", led_w[0], 0);
        wait_drain("drain_single", 300);

        // Transform table
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].din, 1'b1, vecs[i].exp);
            wait_drain("drain_table", 300);
        end

        // Burst of 20 while the first word is in flight
        for (int i = 0; i < 20; i++) send(8'(i), (i <= 16), model(8'(i)));
        check("burst_level_full", level_w[0], 16);
        check("burst_overflow", overflow_w[0], 1);
        check("burst_drop_count", drop_w[0], 3);
        rx_ready     = 1'b1;
        rx_data      = 8'hAA;
        overflow_clr = 1'b1;
        tick();
        rx_ready     = 1'b0;
        check("clr_vs_drop_overflow", overflow_w[0], 1);
        check("clr_vs_drop_count", drop_w[0], 1);
        tick();
        overflow_clr = 1'b0;
        check("clr_overflow", overflow_w[0], 0);
        check("clr_drop_count", drop_w[0], 0);
        wait_drain("drain_burst", 3000);

        // Full FIFO with a push on the same edge as the IDLE pop
        tx_auto  = 1'b0;
        man_busy = 1'b1;
        for (int i = 0; i < 16; i++) send(8'h61 + 8'(i), 1'b1, model(8'h61 + 8'(i)));
        check("fill_level", level_w[0], 16);
        check("fill_no_start", tx_start_w[0], 0);
        rx_ready = 1'b1;
        rx_data  = 8'h7A;
        man_busy = 1'b0;
        sb.push_back(model(8'h7A));
        tick();
        rx_ready = 1'b0;
        check("push_pop_full_level", level_w[0], 16);
        check("push_pop_full_overflow", overflow_w[0], 0);
        check("push_pop_full_drops", drop_w[0], 0);
        check("push_pop_full_start", tx_start_w[0], 1);
        set_auto();
        wait_drain("drain_full", 3000);

        // Transmitter never acknowledges
        tx_auto  = 1'b0;
        man_busy = 1'b0;
        rx_ready = 1'b1;
        rx_data  = 8'h11;
        sb.push_back(model(8'h11));
        tick();
        rx_data  = 8'h22;
        sb.push_back(model(8'h22));
        tick();
        rx_ready = 1'b0;
        check("tmo_first_start", tx_start_w[0], 1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tx_start_w[0]) n++;
            else break;
        end
        check("tmo_start_cycles", 32'(n), TMO);
        check("tmo_flag_set", tmo_w[0], 1);
        tick();
        check("tmo_next_issue", tx_start_w[0], 1);
        for (int i = 0; i < 40 && tx_start_w[0]; i++) tick();
        check("tmo_second_expired", tx_start_w[0], 0);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("tmo_flag_cleared", tmo_w[0], 0);
        check("tmo_sb_empty", 32'(sb.size()), 0);

        // Asynchronous reset in WAIT_BUSY with words queued
        for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), 1'b1, model(8'h30 + 8'(i)));
        check("pre_rst_level", level_w[0], 5);
        check("pre_rst_start", tx_start_w[0], 1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_start", tx_start_w[0], 0);
        check("async_rst_level", level_w[0], 0);
        check("async_rst_led", led_w[0], 0);
        check("async_rst_data", tx_data_w[0], 0);
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_start_w[0]) n++;
        end
        check("no_start_after_reset", 32'(n), 0);
        set_auto();
        send(8'h55, 1'b1, model(8'h55));
        wait_drain("drain_after_reset", 300);
        check("final_level", level_w[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
